// File: rtl/msdap_pkg.sv
// Shared constants and scheduler state encoding for the MSDAP output path.
package msdap_pkg;

  localparam int DATA_W      = 40;
  localparam int SHIFT_LEN   = 40;
  localparam int FRAME_SLOTS = 2 * SHIFT_LEN;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_L  = 3'd1,
    ST_SHIFT_L = 3'd2,
    ST_LOAD_R  = 3'd3,
    ST_SHIFT_R = 3'd4
  } sched_state_t;

endpackage

// File: rtl/p2s_chan_buf.sv
// One-entry valid/ready holding register for a channel result.
// A consume and an accept in the same cycle refill the entry.
module p2s_chan_buf #(
  parameter int DATA_W = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              consume_i,
  output logic              ready_o,
  output logic              full_o,
  output logic [DATA_W-1:0] data_o
);

  logic              full_q;
  logic [DATA_W-1:0] data_q;
  logic              accept;

  assign ready_o = ~full_q | consume_i;
  assign accept  = valid_i & ready_o;
  assign full_o  = full_q;
  assign data_o  = data_q;

  // NOTE: the data word is reset too; it is a single register, not a RAM, and a
  // known value keeps an underrun-free first frame deterministic after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (accept) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (consume_i) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/p2s_sched.sv
// Frame scheduler sharing one P2S serializer between the left and right
// channel datapaths: left word at slot 0, right word at slot SHIFT_LEN.
module p2s_sched #(
  parameter int DATA_W    = 40,
  parameter int SHIFT_LEN = 40
) (
  input  logic              SCLK,
  input  logic              CLR_N,
  input  logic              FRAME,
  input  logic              L_VALID,
  input  logic [DATA_W-1:0] L_DATA,
  output logic              L_READY,
  input  logic              R_VALID,
  input  logic [DATA_W-1:0] R_DATA,
  output logic              R_READY,
  output logic              P2S_LOAD,
  output logic [DATA_W-1:0] P2S_PDATA,
  output logic              P2S_CLR,
  output logic              CH_SEL,
  output logic              BUSY,
  output logic [1:0]        UNDERRUN,
  output logic              OVERRUN,
  input  logic              ERR_CLR
);

  import msdap_pkg::*;

  localparam logic [6:0] C_LAST_L = 7'(SHIFT_LEN - 1);
  localparam logic [6:0] C_END    = 7'(2 * SHIFT_LEN);
  localparam logic [6:0] C_MAX    = 7'h7F;

  sched_state_t      state_q, state_d;
  logic [6:0]        c_q, c_d;
  logic              l_take_q, r_take_q;
  logic              load_q, load_d;
  logic [DATA_W-1:0] pdata_q, pdata_d;
  logic              ch_sel_q, ch_sel_d;
  logic              busy_q, busy_d;
  logic [1:0]        under_q, under_d;
  logic              over_q, over_d;

  logic              l_full, r_full;
  logic [DATA_W-1:0] l_data, r_data;
  logic              consume_l, consume_r;
  logic              frame_ok, enter_load_r;

  // A buffer is emptied only if its word was the one actually loaded.
  assign consume_l = (state_q == ST_LOAD_L) & l_take_q;
  assign consume_r = (state_q == ST_LOAD_R) & r_take_q;

  p2s_chan_buf #(.DATA_W(DATA_W)) u_buf_l (
    .clk      (SCLK),
    .rst_n    (CLR_N),
    .valid_i  (L_VALID),
    .data_i   (L_DATA),
    .consume_i(consume_l),
    .ready_o  (L_READY),
    .full_o   (l_full),
    .data_o   (l_data)
  );

  p2s_chan_buf #(.DATA_W(DATA_W)) u_buf_r (
    .clk      (SCLK),
    .rst_n    (CLR_N),
    .valid_i  (R_VALID),
    .data_i   (R_DATA),
    .consume_i(consume_r),
    .ready_o  (R_READY),
    .full_o   (r_full),
    .data_o   (r_data)
  );

  // Last slot of a frame also accepts FRAME, giving gapless back-to-back frames.
  assign frame_ok     = FRAME & ((state_q == ST_IDLE) |
                                 ((state_q == ST_SHIFT_R) & (c_q == C_END)));
  assign enter_load_r = (state_q == ST_SHIFT_L) & (c_q == C_LAST_L);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    c_d     = (c_q == C_MAX) ? c_q : c_q + 7'd1;
    unique case (state_q)
      ST_IDLE:    state_d = ST_IDLE;
      ST_LOAD_L:  state_d = ST_SHIFT_L;
      ST_SHIFT_L: if (c_q == C_LAST_L) state_d = ST_LOAD_R;
      ST_LOAD_R:  state_d = ST_SHIFT_R;
      ST_SHIFT_R: if (c_q == C_END) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (frame_ok) begin
      state_d = ST_LOAD_L;
      c_d     = 7'd0;
    end
  end

  always_comb begin
    load_d   = (state_d == ST_LOAD_L) | (state_d == ST_LOAD_R);
    busy_d   = (state_d != ST_IDLE);
    ch_sel_d = (state_d == ST_SHIFT_R);
    pdata_d  = '0;
    if (frame_ok && l_full)     pdata_d = l_data;
    if (enter_load_r && r_full) pdata_d = r_data;
    under_d    = ERR_CLR ? 2'b00 : under_q;
    under_d[0] = under_d[0] | (frame_ok & ~l_full);
    under_d[1] = under_d[1] | (enter_load_r & ~r_full);
    over_d     = (ERR_CLR ? 1'b0 : over_q) | (FRAME & busy_q & ~frame_ok);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge SCLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q  <= ST_IDLE;
      c_q      <= C_MAX;
      l_take_q <= 1'b0;
      r_take_q <= 1'b0;
      load_q   <= 1'b0;
      pdata_q  <= '0;
      ch_sel_q <= 1'b0;
      busy_q   <= 1'b0;
      under_q  <= 2'b00;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      if (frame_ok)     l_take_q <= l_full;
      if (enter_load_r) r_take_q <= r_full;
      load_q   <= load_d;
      pdata_q  <= pdata_d;
      ch_sel_q <= ch_sel_d;
      busy_q   <= busy_d;
      under_q  <= under_d;
      over_q   <= over_d;
    end
  end

  assign P2S_LOAD  = load_q;
  assign P2S_PDATA = pdata_q;
  assign P2S_CLR   = ~CLR_N;
  assign CH_SEL    = ch_sel_q;
  assign BUSY      = busy_q;
  assign UNDERRUN  = under_q;
  assign OVERRUN   = over_q;

endmodule

// File: tb/tb_p2s_sched.sv
// Scoreboard bench for p2s_sched: a slot-position model predicts the loaded
// words and per-cycle flags; a monitor pops expected words on every LOAD.
module tb_p2s_sched;
  import msdap_pkg::*;

  logic              SCLK, CLR_N, FRAME, L_VALID, R_VALID, ERR_CLR;
  logic [DATA_W-1:0] L_DATA, R_DATA, P2S_PDATA;
  logic              L_READY, R_READY, P2S_LOAD, P2S_CLR, CH_SEL, BUSY, OVERRUN;
  logic [1:0]        UNDERRUN;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: frame position (-1 = idle), buffer contents, sticky flags.
  int                fpos = -1;
  bit                m_lfull, m_rfull, m_lused, m_rused, m_over;
  bit                last_acc_l, last_acc_r;
  logic [DATA_W-1:0] m_ldata, m_rdata;
  logic [1:0]        m_under;
  logic [DATA_W-1:0] exp_q[$];

  p2s_sched #(.DATA_W(DATA_W), .SHIFT_LEN(SHIFT_LEN)) dut (
    .SCLK(SCLK), .CLR_N(CLR_N), .FRAME(FRAME),
    .L_VALID(L_VALID), .L_DATA(L_DATA), .L_READY(L_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_READY(R_READY),
    .P2S_LOAD(P2S_LOAD), .P2S_PDATA(P2S_PDATA), .P2S_CLR(P2S_CLR),
    .CH_SEL(CH_SEL), .BUSY(BUSY), .UNDERRUN(UNDERRUN), .OVERRUN(OVERRUN),
    .ERR_CLR(ERR_CLR)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready_l();
    return !m_lfull || (fpos == 0 && m_lused);
  endfunction

  function automatic bit exp_ready_r();
    return !m_rfull || (fpos == SHIFT_LEN && m_rused);
  endfunction

  task automatic model_reset();
    fpos = -1;
    m_lfull = 0; m_rfull = 0; m_lused = 0; m_rused = 0;
    m_ldata = '0; m_rdata = '0;
    m_under = 2'b00; m_over = 0;
    exp_q.delete();
  endtask

  // Called just after a negedge: drive, let the edge happen, update model, check.
  task automatic step(input bit f, input bit lv, input logic [DATA_W-1:0] ld,
                      input bit rv, input logic [DATA_W-1:0] rd, input bit ec);
    bit rl, rr, fr_ok, ov;
    logic [1:0] set_u;
    FRAME = f; L_VALID = lv; L_DATA = ld; R_VALID = rv; R_DATA = rd; ERR_CLR = ec;
    @(posedge SCLK);
    rl    = exp_ready_l();
    rr    = exp_ready_r();
    fr_ok = f && (fpos < 0 || fpos == FRAME_SLOTS);
    ov    = f && fpos >= 0 && fpos < FRAME_SLOTS;
    set_u = 2'b00;
    if (fr_ok) begin
      exp_q.push_back(m_lfull ? m_ldata : '0);
      set_u[0] = !m_lfull;
      m_lused  = m_lfull;
    end
    if (fpos == SHIFT_LEN - 1) begin
      exp_q.push_back(m_rfull ? m_rdata : '0);
      set_u[1] = !m_rfull;
      m_rused  = m_rfull;
    end
    if (fpos == 0 && m_lused)         m_lfull = 0;
    if (fpos == SHIFT_LEN && m_rused) m_rfull = 0;
    last_acc_l = lv && rl;
    last_acc_r = rv && rr;
    if (last_acc_l) begin m_lfull = 1; m_ldata = ld; end
    if (last_acc_r) begin m_rfull = 1; m_rdata = rd; end
    m_under = (ec ? 2'b00 : m_under) | set_u;
    m_over  = (ec ? 1'b0 : m_over) | ov;
    if (fr_ok)                     fpos = 0;
    else if (fpos == FRAME_SLOTS)  fpos = -1;
    else if (fpos >= 0)            fpos = fpos + 1;
    @(negedge SCLK);
    check("busy",     64'(BUSY),     64'(fpos >= 0));
    check("ch_sel",   64'(CH_SEL),   64'(fpos > SHIFT_LEN));
    check("load",     64'(P2S_LOAD), 64'(fpos == 0 || fpos == SHIFT_LEN));
    check("l_ready",  64'(L_READY),  64'(exp_ready_l()));
    check("r_ready",  64'(R_READY),  64'(exp_ready_r()));
    check("underrun", 64'(UNDERRUN), 64'(m_under));
    check("overrun",  64'(OVERRUN),  64'(m_over));
    check("p2s_clr",  64'(P2S_CLR),  64'(0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load"},  64'(P2S_LOAD),  64'(0));
    check({tag, "_pdata"}, 64'(P2S_PDATA), 64'(0));
    check({tag, "_chsel"}, 64'(CH_SEL),    64'(0));
    check({tag, "_busy"},  64'(BUSY),      64'(0));
    check({tag, "_under"}, 64'(UNDERRUN),  64'(0));
    check({tag, "_over"},  64'(OVERRUN),   64'(0));
    check({tag, "_clr"},   64'(P2S_CLR),   64'(1));
    check({tag, "_lrdy"},  64'(L_READY),   64'(1));
    check({tag, "_rrdy"},  64'(R_READY),   64'(1));
  endtask

  // Monitor: every LOAD must match the oldest expected word.
  initial begin : monitor
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge SCLK);
      if (CLR_N === 1'b1 && P2S_LOAD === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("load_unexpected", 64'(P2S_LOAD), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("pdata", 64'(P2S_PDATA), 64'(e));
        end
      end
    end
  end

  initial begin : stimulus
    logic [63:0]       rnd;
    logic [DATA_W-1:0] l_cnt, r_cnt;
    CLR_N = 1'b0; FRAME = 0; L_VALID = 0; R_VALID = 0; ERR_CLR = 0;
    L_DATA = '0; R_DATA = '0;
    model_reset();
    #3;
    check_reset_outputs("por");
    repeat (2) @(negedge SCLK);
    CLR_N = 1'b1;

    // 1: both channels posted, one frame.
    step(0, 1, 40'h80_0000_0001, 1, 40'h00_FFFF_FFFE, 0);
    idle(2);
    step(1, 0, '0, 0, '0, 0);
    idle(FRAME_SLOTS + 1);
    check("t1_idle", 64'(BUSY), 64'(0));

    // 2: only left posted; right slot underruns.
    step(0, 1, 40'h12_3456_789A, 0, '0, 0);
    step(1, 0, '0, 0, '0, 0);
    idle(FRAME_SLOTS + 1);
    check("t2_underrun", 64'(UNDERRUN), 64'(2'b10));
    check("t2_l_empty",  64'(L_READY),  64'(1));
    step(0, 0, '0, 0, '0, 1);
    check("t2_errclr", 64'(UNDERRUN), 64'(0));

    // 3: second FRAME at c=20 is ignored and flags overrun.
    step(0, 1, 40'hAA_5555_AAAA, 1, 40'h55_AAAA_5555, 0);
    step(1, 0, '0, 0, '0, 0);
    idle(20);
    step(1, 0, '0, 0, '0, 0);
    check("t3_overrun", 64'(OVERRUN), 64'(1));
    idle(FRAME_SLOTS);
    step(0, 0, '0, 0, '0, 1);
    check("t3_errclr_o", 64'(OVERRUN),  64'(0));
    check("t3_errclr_u", 64'(UNDERRUN), 64'(0));

    // 4: new left word held through the c=0 edge goes to the next frame.
    step(0, 1, 40'h01_0000_0001, 1, 40'h02_0000_0002, 0);
    step(1, 1, 40'h0B_0000_000B, 0, '0, 0);
    check("t4_ready_c0", 64'(L_READY), 64'(1));
    step(0, 1, 40'h0B_0000_000B, 0, '0, 0);
    idle(FRAME_SLOTS + 1);
    step(1, 0, '0, 0, '0, 0);
    idle(FRAME_SLOTS + 1);
    step(0, 0, '0, 0, '0, 1);

    // 5: asynchronous reset mid-frame at c=55.
    step(0, 1, 40'hC0_FFEE_0001, 1, 40'hC1_FFEE_0002, 0);
    step(1, 0, '0, 0, '0, 0);
    idle(55);
    #2 CLR_N = 1'b0;
    #1 check_reset_outputs("arst");
    model_reset();
    repeat (3) begin
      @(negedge SCLK);
      check("arst_noload", 64'(P2S_LOAD), 64'(0));
    end
    CLR_N = 1'b1;
    step(0, 1, 40'hD0_0000_00D0, 1, 40'hD1_0000_00D1, 0);
    step(1, 0, '0, 0, '0, 0);
    idle(FRAME_SLOTS + 1);

    // 6: ten back-to-back frames with incrementing data.
    l_cnt = 40'h10_0000_0000;
    r_cnt = 40'h20_0000_0000;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j <= FRAME_SLOTS; j++) begin
        step(j == 0, 1, l_cnt, 1, r_cnt, 0);
        if (last_acc_l) l_cnt = l_cnt + 40'd1;
        if (last_acc_r) r_cnt = r_cnt + 40'd1;
      end
    end
    idle(FRAME_SLOTS + 1);
    check("t6_no_overrun", 64'(OVERRUN), 64'(0));

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [DATA_W-1:0] ld, rd;
      rnd = {$urandom, $urandom};
      ld  = rnd[DATA_W-1:0];
      rnd = {$urandom, $urandom};
      rd  = rnd[DATA_W-1:0];
      step($urandom_range(0, 99) < 3, $urandom_range(0, 1) == 1, ld,
           $urandom_range(0, 1) == 1, rd, $urandom_range(0, 99) == 0);
    end
    idle(FRAME_SLOTS + 2);
    check("queue_drain", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
